// File: rtl/rx_byte_aligner.sv
// rx_byte_aligner: 2-byte K28.5 comma aligner with HUNT/VERIFY/LOCKED lock tracking.
// Optional define ALIGNER_STATS_EN enables the LOCKED->HUNT event counter on realign_cnt_o.
module rx_byte_aligner #(
    parameter logic [7:0]  g_COMMA      = 8'hBC,
    parameter int unsigned g_LOCK_COUNT = 4,
    parameter int unsigned g_MAX_ERRORS = 4
) (
    input  logic        usrclk_i,
    input  logic        rst_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    input  logic        realign_i,
    output logic [15:0] rx_data_o,
    output logic [1:0]  rx_k_o,
    output logic        aligned_o,
    output logic        gt_realign_o,
    output logic        byte_shift_o,
    output logic [15:0] realign_cnt_o
);

    localparam logic [7:0] LOCK_CNT = 8'(g_LOCK_COUNT);
    localparam logic [7:0] MAX_ERR  = 8'(g_MAX_ERRORS);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'h00) ? v : v - 8'd1;
    endfunction

    state_t      state, state_nxt;
    logic        shift_nxt;
    logic [7:0]  vcnt, vcnt_nxt, vcnt_inc;
    logic [7:0]  score, score_nxt;
    logic [15:0] prev_data_p0;
    logic [1:0]  prev_k_p0;
    logic        hi_c, lo_c, good, bad;

    assign hi_c = rx_k_i[1] && (rx_data_i[15:8] == g_COMMA);
    assign lo_c = rx_k_i[0] && (rx_data_i[7:0] == g_COMMA);
    assign good = byte_shift_o ? lo_c : hi_c;
    assign bad  = byte_shift_o ? hi_c : lo_c;

    // Stage p0 -> output: previous word held so a slipped word can be re-formed across the boundary
    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_data_p0 <= '0;
            prev_k_p0    <= '0;
            rx_data_o    <= '0;
            rx_k_o       <= '0;
        end else begin
            prev_data_p0 <= rx_data_i;
            prev_k_p0    <= rx_k_i;
            if (byte_shift_o) begin
                rx_data_o <= {prev_data_p0[7:0], rx_data_i[15:8]};
                rx_k_o    <= {prev_k_p0[0], rx_k_i[1]};
            end else begin
                rx_data_o <= rx_data_i;
                rx_k_o    <= rx_k_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = byte_shift_o;
        vcnt_nxt  = vcnt;
        score_nxt = score;
        vcnt_inc  = sat_inc8(vcnt);
        if (realign_i) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    if (hi_c) begin
                        shift_nxt = 1'b0;
                        state_nxt = VERIFY;
                        vcnt_nxt  = 8'd1;
                    end else if (lo_c) begin
                        shift_nxt = 1'b1;
                        state_nxt = VERIFY;
                        vcnt_nxt  = 8'd1;
                    end
                end
                VERIFY: begin
                    if (bad) begin
                        state_nxt = HUNT;
                    end else if (good) begin
                        vcnt_nxt = vcnt_inc;
                        if (vcnt_inc >= LOCK_CNT) begin
                            state_nxt = LOCKED;
                            score_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (bad) begin
                        score_nxt = sat_inc8(score);
                    end else if (good) begin
                        score_nxt = sat_dec8(score);
                    end
                    if (score_nxt == MAX_ERR) begin
                        state_nxt = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        if (state_nxt == HUNT) begin
            vcnt_nxt  = '0;
            score_nxt = '0;
        end
    end

    // Status flags are decodes of the next state so they change on the same edge as the state
    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= HUNT;
            byte_shift_o <= 1'b0;
            vcnt         <= '0;
            score        <= '0;
            aligned_o    <= 1'b0;
            gt_realign_o <= 1'b1;
        end else begin
            state        <= state_nxt;
            byte_shift_o <= shift_nxt;
            vcnt         <= vcnt_nxt;
            score        <= score_nxt;
            aligned_o    <= (state_nxt == LOCKED);
            gt_realign_o <= (state_nxt == HUNT);
        end
    end

`ifdef ALIGNER_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic lost_lock;
    assign lost_lock = (state == LOCKED) && (state_nxt == HUNT);

    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            realign_cnt_o <= '0;
        end else if (lost_lock) begin
            realign_cnt_o <= sat_inc16(realign_cnt_o);
        end
    end
`else
    assign realign_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rx_byte_aligner.sv
// Self-checking bench for rx_byte_aligner: scoreboarded data path, table-driven VERIFY abort,
// hand sequences for error scoring, forced realign and asynchronous reset.
module tb_rx_byte_aligner;

    logic        usrclk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] rx_data_i = '0;
    logic [1:0]  rx_k_i = '0;
    logic        realign_i = 1'b0;
    logic [15:0] rx_data_o;
    logic [1:0]  rx_k_o;
    logic        aligned_o;
    logic        gt_realign_o;
    logic        byte_shift_o;
    logic [15:0] realign_cnt_o;

`ifdef ALIGNER_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    rx_byte_aligner dut (
        .usrclk_i     (usrclk_i),
        .rst_i        (rst_i),
        .rx_data_i    (rx_data_i),
        .rx_k_i       (rx_k_i),
        .realign_i    (realign_i),
        .rx_data_o    (rx_data_o),
        .rx_k_o       (rx_k_o),
        .aligned_o    (aligned_o),
        .gt_realign_o (gt_realign_o),
        .byte_shift_o (byte_shift_o),
        .realign_cnt_o(realign_cnt_o)
    );

    always #5 usrclk_i = ~usrclk_i;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        bit          chk;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        logic        ra;
        logic        e_al;
        logic        e_gtr;
        logic        e_sh;
        bit          chk_d;
        logic [15:0] e_d;
        logic [1:0]  e_k;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[15];
    int          checks = 0;
    int          errors = 0;
    int          tb_commas = 0;
    int          exp_cnt = 0;
    logic [15:0] prev_l = '0;
    logic [1:0]  prev_lk = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one word, queue its expected output, and compare once the edge has produced it
    task automatic step(input logic [15:0] d, input logic [1:0] k, input logic ra,
                        input logic [15:0] ed, input logic [1:0] ek, input bit c);
        exp_t e;
        e.d = ed;
        e.k = ek;
        e.chk = c;
        rx_data_i = d;
        rx_k_i    = k;
        realign_i = ra;
        sbq.push_back(e);
        @(posedge usrclk_i);
        #1;
        realign_i = 1'b0;
        e = sbq.pop_front();
        if (e.chk) begin
            chk("rx_data", rx_data_o, e.d);
            chk("rx_k", rx_k_o, e.k);
        end
    endtask

    task automatic pay();
        logic [15:0] w = 16'($urandom);
        step(w, 2'b00, 1'b0, w, 2'b00, 1'b1);
        prev_l  = w;
        prev_lk = 2'b00;
    endtask

    task automatic bad_lane();
        logic [15:0] w = {8'($urandom), 8'hBC};
        step(w, 2'b01, 1'b0, w, 2'b01, 1'b1);
        prev_l  = w;
        prev_lk = 2'b01;
    endtask

    // Logical stream with an IDLE every 'period' words; slip=1 presents it one byte late
    task automatic run_stream(input int n, input int period, input bit slip);
        for (int i = 0; i < n; i++) begin
            logic [15:0] l, din, ed;
            logic [1:0]  lk, kin, ek;
            bit          idle, dok;
            idle = ((i % period) == 1);
            l    = idle ? 16'hbc95 : 16'($urandom);
            lk   = idle ? 2'b10 : 2'b00;
            if (slip) begin
                din = {prev_l[7:0], l[15:8]};
                kin = {prev_lk[0], lk[1]};
                ed  = prev_l;
                ek  = prev_lk;
            end else begin
                din = l;
                kin = lk;
                ed  = l;
                ek  = lk;
            end
            dok = (tb_commas >= 1);
            step(din, kin, 1'b0, ed, ek, dok);
            prev_l  = l;
            prev_lk = lk;
            if (idle) tb_commas++;
            chk("aligned", aligned_o, 32'(tb_commas >= 4));
            chk("gt_realign", gt_realign_o, 32'(tb_commas == 0));
            if (dok) chk("byte_shift", byte_shift_o, 32'(slip));
        end
    endtask

    initial begin
        //         d         k      ra    al    gtr   sh    chk  e_d       e_k
        tbl[0]  = '{16'h0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00};
        tbl[1]  = '{16'hbc95, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hbc95, 2'b10};
        tbl[2]  = '{16'h1234, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 2'b00};
        tbl[3]  = '{16'hbc95, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00};
        tbl[4]  = '{16'h5678, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00};
        tbl[5]  = '{16'h12bc, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00};
        tbl[6]  = '{16'h9512, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00};
        tbl[7]  = '{16'h34bc, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
        tbl[8]  = '{16'h9500, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hbc95, 2'b10};
        tbl[9]  = '{16'h00bc, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
        tbl[10] = '{16'h9511, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
        tbl[11] = '{16'h22bc, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
        tbl[12] = '{16'h9533, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00};
        tbl[13] = '{16'h44bc, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3344, 2'b00};
        tbl[14] = '{16'h9555, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hbc95, 2'b10};

        // Reset state
        #1 rst_i = 1'b1;
        #2;
        chk("rst_data", rx_data_o, 32'h0);
        chk("rst_k", rx_k_o, 32'h0);
        chk("rst_aligned", aligned_o, 32'h0);
        chk("rst_gt_realign", gt_realign_o, 32'h1);
        chk("rst_shift", byte_shift_o, 32'h0);
        chk("rst_cnt", realign_cnt_o, 32'h0);
        @(posedge usrclk_i);
        #1 rst_i = 1'b0;

        // Aligned stream, IDLE every 193 words
        tb_commas = 0;
        run_stream(193 * 5, 193, 1'b0);

        // Error scoring while LOCKED on lane 0
        bad_lane(); pay(); bad_lane(); pay(); bad_lane(); pay();
        chk("score3_locked", aligned_o, 32'h1);
        step(16'hbc95, 2'b10, 1'b0, 16'hbc95, 2'b10, 1'b1);
        chk("score2_locked", aligned_o, 32'h1);
        bad_lane();
        chk("score3b_locked", aligned_o, 32'h1);
        bad_lane();
        pay(); pay();
        exp_cnt += STATS_ON;
        chk("score4_aligned", aligned_o, 32'h0);
        chk("score4_gt_realign", gt_realign_o, 32'h1);
        chk("score4_cnt", realign_cnt_o, 32'(exp_cnt));

        // VERIFY aborted by a wrong-lane comma, then relock on the other lane
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].d, tbl[i].k, tbl[i].ra, tbl[i].e_d, tbl[i].e_k, tbl[i].chk_d);
            chk($sformatf("tbl%0d_aligned", i), aligned_o, 32'(tbl[i].e_al));
            chk($sformatf("tbl%0d_gt_realign", i), gt_realign_o, 32'(tbl[i].e_gtr));
            chk($sformatf("tbl%0d_shift", i), byte_shift_o, 32'(tbl[i].e_sh));
        end
        chk("verify_abort_cnt", realign_cnt_o, 32'(exp_cnt));

        // One-cycle realign pulse while LOCKED
        step(16'h0123, 2'b00, 1'b1, 16'h0, 2'b00, 1'b0);
        exp_cnt += STATS_ON;
        chk("realign_aligned", aligned_o, 32'h0);
        chk("realign_gt_realign", gt_realign_o, 32'h1);
        chk("realign_shift_held", byte_shift_o, 32'h1);
        chk("realign_cnt", realign_cnt_o, 32'(exp_cnt));
        step(16'h4567, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0);
        chk("realign_hunt_hold", gt_realign_o, 32'h1);
        prev_l  = 16'h4567;
        prev_lk = 2'b00;

        // Byte-slipped stream acquired from HUNT
        tb_commas = 0;
        run_stream(16 * 6, 16, 1'b1);

        // Asynchronous reset between edges while LOCKED mid-payload
        #2 rst_i = 1'b1;
        #1;
        chk("arst_data", rx_data_o, 32'h0);
        chk("arst_k", rx_k_o, 32'h0);
        chk("arst_aligned", aligned_o, 32'h0);
        chk("arst_gt_realign", gt_realign_o, 32'h1);
        chk("arst_shift", byte_shift_o, 32'h0);
        chk("arst_cnt", realign_cnt_o, 32'h0);
        @(posedge usrclk_i);
        #1 rst_i = 1'b0;
        sbq.delete();
        exp_cnt   = 0;
        tb_commas = 0;

        // Relock after reset
        run_stream(16 * 5, 16, 1'b0);
        chk("final_cnt", realign_cnt_o, 32'(exp_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
